// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared ALU op codes and mul/div sequencer state encoding for hilo_muldiv_unit.
// Optional single-cycle multiplier is selected by MULDIV_FAST_MUL_EN.
package hilo_muldiv_unit_pkg;

  localparam int unsigned ALU_OP_WIDTH = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL  = 5'd24;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULU = 5'd25;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV  = 5'd26;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU = 5'd27;

  localparam logic [1:0] MULDIV_STATE_IDLE = 2'd0;
  localparam logic [1:0] MULDIV_STATE_CALC = 2'd1;
  localparam logic [1:0] MULDIV_STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = MULDIV_STATE_IDLE,
    StCalc = MULDIV_STATE_CALC,
    StDone = MULDIV_STATE_DONE
  } muldiv_state_e;

  function automatic logic op_is_mul(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_MULU);
  endfunction

  function automatic logic op_is_div(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO mul/div sequencer.
interface hilo_muldiv_unit_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 5
);

  logic                    flush;
  logic                    start;
  logic [ALU_OP_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0]   rs;
  logic [DATA_WIDTH-1:0]   rt;
  logic                    wr_hi;
  logic                    wr_lo;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    busy;
  logic                    done;
  logic [DATA_WIDTH-1:0]   hi;
  logic [DATA_WIDTH-1:0]   lo;

  modport master (
    output flush, start, op, rs, rt, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  flush, start, op, rs, rt, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_unit_datapath.sv
// Shared radix-2 shift-add / restoring shift-subtract datapath with sign fix-up.
// MULDIV_FAST_MUL_EN adds a combinational full-width product output.
module hilo_muldiv_unit_datapath #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
`ifdef MULDIV_FAST_MUL_EN
  output logic [DATA_WIDTH-1:0] mul_hi,
  output logic [DATA_WIDTH-1:0] mul_lo,
`endif
  output logic [DATA_WIDTH-1:0] res_hi,
  output logic [DATA_WIDTH-1:0] res_lo
);

  localparam int unsigned W = DATA_WIDTH;

  logic [2*W-1:0] acc_q, acc_nxt, mul_step, div_step, prod_fix;
  logic [W-1:0]   opnd_q;
  logic           is_div_q, neg_res_q, neg_rem_q;
  logic           rs_neg, rt_neg;
  logic [W-1:0]   rs_mag, rt_mag;
  logic [W:0]     mul_sum, div_shift;
  logic [W-1:0]   div_rem, quo_fix, rem_fix;
  logic           div_qbit;

  always_comb begin
    rs_neg = is_signed & rs[W-1];
    rt_neg = is_signed & rt[W-1];
    rs_mag = rs_neg ? -rs : rs;
    rt_mag = rt_neg ? -rt : rt;
  end

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (load) begin
      acc_q     <= is_div ? {{W{1'b0}}, rs_mag} : {{W{1'b0}}, rt_mag};
      opnd_q    <= is_div ? rt_mag : rs_mag;
      is_div_q  <= is_div;
      neg_res_q <= rs_neg ^ rt_neg;
      neg_rem_q <= rs_neg;
    end else if (step) begin
      acc_q <= acc_nxt;
    end
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[W-1:1]};

    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_qbit  = div_shift >= {1'b0, opnd_q};
    div_rem   = div_qbit ? W'(div_shift - {1'b0, opnd_q}) : div_shift[W-1:0];
    div_step  = {div_rem, acc_q[W-2:0], div_qbit};

    acc_nxt = is_div_q ? div_step : mul_step;

    // Fix-up applies to the value the final step produces, so HI/LO load in one edge.
    prod_fix = neg_res_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_res_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
    rem_fix  = neg_rem_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];

    res_hi = is_div_q ? rem_fix : prod_fix[2*W-1:W];
    res_lo = is_div_q ? quo_fix : prod_fix[W-1:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] fast_a, fast_b, fast_prod;

  always_comb begin
    fast_a    = {{W{rs_neg}}, rs};
    fast_b    = {{W{rt_neg}}, rt};
    fast_prod = fast_a * fast_b;
    mul_hi    = fast_prod[2*W-1:W];
    mul_lo    = fast_prod[W-1:0];
  end
`endif

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle mul/div sequencer owning the HI/LO pair; raises busy while iterating.
// Define MULDIV_FAST_MUL_EN to retire MUL/MULU through a single-cycle multiplier.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 5
) (
  input logic               clk,
  input logic               rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  muldiv_state_e         state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_WIDTH-1:0] res_hi, res_lo;
  logic                  is_mul, is_div, is_signed, accept, load, step;
`ifdef MULDIV_FAST_MUL_EN
  logic [DATA_WIDTH-1:0] mul_hi, mul_lo;
`endif

  always_comb begin
    is_mul    = op_is_mul(bus.op);
    is_div    = op_is_div(bus.op);
    is_signed = op_is_signed(bus.op);
    accept    = (state_q != StCalc) && bus.start && (is_mul || is_div) && !bus.flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
          if (is_mul) begin
            state_d = StDone;
            hi_d    = mul_hi;
            lo_d    = mul_lo;
          end else begin
            load    = 1'b1;
            count_d = '0;
            state_d = StCalc;
          end
`else
          load    = 1'b1;
          count_d = '0;
          state_d = StCalc;
`endif
        end else begin
          // A start that loses to nothing still blocks MTHI/MTLO; only idle writes land.
          state_d = StIdle;
          if (bus.wr_hi && !bus.start) hi_d = bus.wr_data;
          if (bus.wr_lo && !bus.start) lo_d = bus.wr_data;
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          step    = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_LAST) begin
            state_d = StDone;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  hilo_muldiv_unit_datapath #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .is_div   (is_div),
    .is_signed(is_signed),
    .rs       (bus.rs),
    .rt       (bus.rt),
`ifdef MULDIV_FAST_MUL_EN
    .mul_hi   (mul_hi),
    .mul_lo   (mul_lo),
`endif
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  always_comb begin
    bus.busy = (state_q == StCalc);
    bus.done = (state_q == StDone);
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed ops, flush, async reset, back-to-back.
// Multiply latency expectation follows MULDIV_FAST_MUL_EN.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned ITER_LAT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 1;
`else
  localparam int unsigned MUL_LAT = ITER_LAT;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.DATA_WIDTH(W), .ALU_OP_WIDTH(5)) bus ();

  hilo_muldiv_unit #(
    .DATA_WIDTH  (W),
    .ALU_OP_WIDTH(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  lat;
    int unsigned  issue;
    string        name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, bus.hi, e.hi);
        check({e.name, "_lo"}, bus.lo, e.lo);
        check({e.name, "_latency"}, cyc - e.issue, e.lat);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!((bus.wr_hi || bus.wr_lo) && bus.busy)) else $error("write while busy");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input int unsigned lat, input string name);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    sb.push_back('{hi: ehi, lo: elo, lat: lat, issue: cyc, name: name});
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bad;
    int unsigned d0;
    int unsigned n;
    bus.flush = 1'b0; bus.start = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;

    #2 rst_n = 1'b0;
    #1;
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // DIVU 100/7 with busy window check over cycles 1..32.
    issue(ALU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, ITER_LAT, "divu_100_7");
    bad = 0;
    repeat (32) begin
      if (bus.busy !== 1'b1) bad++;
      tick();
    end
    check("divu_busy_window_misses", bad, 0);
    check("busy_in_done_cycle", bus.busy, 0);
    wait_drain(60);

    issue(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, ITER_LAT, "div_m7_2");
    wait_drain(60);
    issue(ALU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT,
          "mulu_max");
    wait_drain(60);
    issue(ALU_OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, "mul_m3_5");
    wait_drain(60);
    issue(ALU_OP_MUL, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MUL_LAT, "mul_7_m6");
    wait_drain(60);
    issue(ALU_OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, ITER_LAT, "divu_by_zero");
    wait_drain(60);
    issue(ALU_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, ITER_LAT, "div_neg_by_zero");
    wait_drain(60);
    issue(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, ITER_LAT, "div_min_m1");
    wait_drain(60);

    // Non-mul/div op with start is ignored.
    d0 = done_seen;
    bus.start = 1'b1; bus.op = 5'd0;
    tick();
    bus.start = 1'b0;
    check("bad_op_busy", bus.busy, 0);
    repeat (3) tick();
    check("bad_op_no_done", done_seen, d0);

    // MTHI / MTLO
    bus.wr_hi = 1'b1; bus.wr_data = 32'h11;
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h22;
    tick();
    bus.wr_lo = 1'b0;
    check("mthi_hi", bus.hi, 32'h11);
    check("mtlo_lo", bus.lo, 32'h22);

    // Flush at cycle 10 of a DIV.
    d0 = done_seen;
    bus.start = 1'b1; bus.op = ALU_OP_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_hi_kept", bus.hi, 32'h11);
    check("flush_lo_kept", bus.lo, 32'h22);
    repeat (40) tick();
    check("flush_no_done", done_seen, d0);

    // Flush in IDLE suppresses a simultaneous start.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = ALU_OP_DIVU;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_idle_busy", bus.busy, 0);
    repeat (2) tick();

    // Asynchronous reset mid-operation.
    bus.start = 1'b1; bus.op = ALU_OP_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", bus.hi, 0);
    check("async_rst_lo", bus.lo, 0);
    check("async_rst_busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Back-to-back: start DIVU 9/3 with wr_lo in the done cycle.
    issue(ALU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, ITER_LAT, "b2b_first");
    n = 0;
    while (!bus.done && n < 60) begin
      tick();
      n++;
    end
    check("b2b_done_seen", bus.done, 1);
    bus.wr_lo = 1'b1; bus.wr_data = 32'hDEAD;
    issue(ALU_OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, ITER_LAT, "b2b_second");
    bus.wr_lo = 1'b0;
    check("b2b_write_dropped", bus.lo, 32'd14);
    check("b2b_second_busy", bus.busy, 1);
    wait_drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
